// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32M funct3 and multiply/divide sequencer state encodings.
package rv32i_types;
   typedef enum logic [2:0] {
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
   } muldiv_funct3_t;
   typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} muldiv_state_t;
endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: shared shift-add / restoring shift-subtract accumulator with final
// sign fix-up, divide-by-zero/overflow overrides and result-word select.
module muldiv_datapath
   import rv32i_types::*;
#(
   parameter int XLEN = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 sa,
   input  logic                 sb,
   input  logic                 mul_step,
   input  logic                 div_step,
   input  logic                 sel_in,
   input  logic [XLEN-1:0]      a,
   input  logic [XLEN-1:0]      b,
   input  muldiv_funct3_t       op_f,
   input  logic                 neg_f,
   input  logic                 dz_f,
   input  logic                 ov_f,
   output logic [XLEN-1:0]      fin
);
   logic [2*XLEN-1:0] acc_q, acc_d, acc_s, mul_n, div_n, prod;
   logic [XLEN-1:0]   dsr_q, dsr_d, a_q, a_d, a_f, quo, rem;
   logic [XLEN:0]     sum, trial;
   always_comb begin
      sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dsr_q} : '0);
      mul_n = {sum, acc_q[XLEN-1:1]};
      // trial subtract on the left-shifted partial remainder; bit XLEN is the borrow
      trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, dsr_q};
      div_n = trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                          : {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      acc_s = mul_step ? mul_n : div_n;
      acc_d = load ? {{XLEN{1'b0}}, (sa ? -a : a)} : (mul_step | div_step) ? acc_s : acc_q;
      dsr_d = load ? (sb ? -b : b) : dsr_q;
      a_d   = load ? a : a_q;
      a_f   = sel_in ? a : a_q;
      prod  = neg_f ? -acc_s : acc_s;
      quo   = neg_f ? -acc_s[XLEN-1:0] : acc_s[XLEN-1:0];
      rem   = neg_f ? -acc_s[2*XLEN-1:XLEN] : acc_s[2*XLEN-1:XLEN];
      fin   = op_f[2] ? (dz_f ? (op_f[1] ? a_f : '1)
                               : ov_f ? (op_f[1] ? '0 : a_f)
                               : op_f[1] ? rem : quo)
                      : (op_f == OP_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q <= '0;
         dsr_q <= '0;
         a_q   <= '0;
      end else begin
         acc_q <= acc_d;
         dsr_q <= dsr_d;
         a_q   <= a_d;
      end
   end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide FSM with stall, done pulse and flush.
// Define MULDIV_DIV_SHORTCUT_EN to finish divide-by-zero/overflow straight from IDLE.
module muldiv_sequencer
   import rv32i_types::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            flush,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);
   localparam int CW = $clog2(XLEN);
   muldiv_state_t   state_q, state_d;
   muldiv_funct3_t  op_q, op_d, op_i, op_f;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] result_q, result_d, fin;
   logic neg_q, neg_d, dz_q, dz_d, ov_q, ov_d, done_q, done_d;
   logic sa, sb, neg_i, dz_i, ov_i, neg_f, dz_f, ov_f, idle, last;
   always_comb begin
      op_i  = muldiv_funct3_t'(op);
      idle  = state_q == ST_IDLE;
      last  = cnt_q == CW'(XLEN-1);
      sa    = a[XLEN-1] & (op_i inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
      sb    = b[XLEN-1] & (op_i inside {OP_MULH, OP_DIV, OP_REM});
      neg_i = op_i == OP_REM ? sa : sa ^ sb;
      dz_i  = b == '0;
      ov_i  = (op_i inside {OP_DIV, OP_REM}) & (a == {1'b1, {(XLEN-1){1'b0}}}) & (&b);
      // in IDLE the final stage sees live inputs so a shortcut can finish immediately
      op_f  = idle ? op_i : op_q;
      neg_f = idle ? neg_i : neg_q;
      dz_f  = idle ? dz_i : dz_q;
      ov_f  = idle ? ov_i : ov_q;
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      neg_d    = neg_q;
      dz_d     = dz_q;
      ov_d     = ov_q;
      done_d   = 1'b0;
      result_d = result_q;
      case (state_q)
         ST_IDLE: if (req) begin
            op_d    = op_i;
            neg_d   = neg_i;
            dz_d    = dz_i;
            ov_d    = ov_i;
            cnt_d   = '0;
            state_d = op_i[2] ? ST_DIV : ST_MUL;
`ifdef MULDIV_DIV_SHORTCUT_EN
            if (op_i[2] & (dz_i | ov_i)) begin
               state_d  = ST_DONE;
               done_d   = 1'b1;
               result_d = fin;
            end
`else
`endif
         end
         ST_MUL, ST_DIV: begin
            cnt_d = cnt_q + 1'b1;
            if (last) begin
               state_d  = ST_DONE;
               done_d   = 1'b1;
               result_d = fin;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (flush) begin
         state_d  = ST_IDLE;
         done_d   = 1'b0;
         result_d = result_q;
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         op_q     <= OP_MUL;
         neg_q    <= 1'b0;
         dz_q     <= 1'b0;
         ov_q     <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         dz_q     <= dz_d;
         ov_q     <= ov_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end
   muldiv_datapath #(.XLEN(XLEN)) u_dp (
      .clk      (clk),
      .rst      (rst),
      .load     (idle & req & ~flush),
      .sa       (sa),
      .sb       (sb),
      .mul_step (state_q == ST_MUL),
      .div_step (state_q == ST_DIV),
      .sel_in   (idle),
      .a        (a),
      .b        (b),
      .op_f     (op_f),
      .neg_f    (neg_f),
      .dz_f     (dz_f),
      .ov_f     (ov_f),
      .fin      (fin)
   );
   assign stall  = rst & req & ~done_q & ~flush;
   assign busy   = (state_q == ST_MUL) | (state_q == ST_DIV);
   assign done   = done_q;
   assign result = result_q;
endmodule
